// File: rtl/uart_rx_oversample.sv
// 16x oversampling UART receiver: 8N1 frames, 2-of-3 mid-bit majority vote,
// single-entry output holding register with overrun and framing-error pulses.
//
// state        | meaning
// S_IDLE       | line idle, waiting for rxs low
// S_START      | validating the start bit
// S_DATA       | shifting in 8 data bits, LSB first
// S_STOP       | sampling the stop bit; decision at sample 9
// S_BREAK_WAIT | stop bit was low; waiting for the line to return high
module uart_rx_oversample #(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 50000000,
  parameter int DATA_BITS  = 8
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = CLOCK_FREQ / (BAUD_RATE * 16);
  localparam int TW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_rx_oversample: CLOCK_FREQ/(BAUD_RATE*16) must be at least 2");
  end
  if (DATA_BITS != 8) begin : g_bad_width
    $error("uart_rx_oversample: only DATA_BITS=8 is supported");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK_WAIT
  } state_t;

  state_t state, state_nxt;

  logic          rx_meta, rxs;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    sample_cnt;
  logic          samp7, samp8, maj;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          at_mid, at_end, start_det, deliver, stop_bad;

  assign tick      = (tick_cnt == TICK_MAX);
  assign at_mid    = tick && (sample_cnt == 4'd9);
  assign at_end    = tick && (sample_cnt == 4'd15);
  // sample 9 is the live rxs, so the vote resolves on the sample-9 tick itself
  assign maj       = (samp7 & samp8) | (samp7 & rxs) | (samp8 & rxs);
  assign start_det = (state == S_IDLE) && !rxs;
  assign deliver   = (state == S_STOP) && at_mid && maj;
  assign stop_bad  = (state == S_STOP) && at_mid && !maj;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!rxs) state_nxt = S_START;
      end
      S_START: begin
        if (at_mid && maj) state_nxt = S_IDLE;
        else if (at_end)   state_nxt = S_DATA;
      end
      S_DATA: begin
        if (at_end && (bit_cnt == 3'd7)) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (at_mid) state_nxt = maj ? S_IDLE : S_BREAK_WAIT;
      end
      S_BREAK_WAIT: begin
        if (rxs) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst || start_det) begin
      tick_cnt   <= '0;
      sample_cnt <= 4'd0;
    end else if (tick) begin
      tick_cnt   <= '0;
      sample_cnt <= sample_cnt + 4'd1;
    end else begin
      tick_cnt   <= tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      samp7   <= 1'b0;
      samp8   <= 1'b0;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      if (tick && (sample_cnt == 4'd7)) samp7 <= rxs;
      if (tick && (sample_cnt == 4'd8)) samp8 <= rxs;
      if (start_det) begin
        bit_cnt <= 3'd0;
      end else if ((state == S_DATA) && at_end) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if ((state == S_DATA) && at_mid) shreg <= {maj, shreg[7:1]};
    end
  end

  // a delivery coinciding with a consume replaces the byte without overrun
  always_ff @(posedge clock) begin
    if (rst) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= deliver && rx_valid && !rx_ready;
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_oversample.md
UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 The block SHALL have parameter BAUD_RATE, default 9600: line bit rate in bits per second.
REQ-002 The block SHALL have parameter CLOCK_FREQ, default 50000000: clock frequency in Hz.
REQ-003 The block SHALL have parameter DATA_BITS, default 8: data bits per frame; only 8 is supported.
REQ-004 The block SHALL derive DIV = CLOCK_FREQ / (BAUD_RATE*16), integer-truncated, and SHALL require DIV >= 2.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port rx, input, 1 bit: asynchronous UART line; idle level is high.
REQ-008 The block SHALL have port rx_data, output, 8 bits: received byte.
REQ-009 The block SHALL have port rx_valid, output, 1 bit: rx_data holds an unconsumed byte.
REQ-010 The block SHALL have port rx_ready, input, 1 bit: consumer accepts rx_data when rx_valid && rx_ready.
REQ-011 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when a stop bit is sampled low.
REQ-012 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed byte is dropped.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 The block SHALL pass rx through a 2-flop synchronizer reset to 1; all logic SHALL use only the synchronized value rxs.
REQ-015 The block SHALL run a tick counter 0..DIV-1 and pulse tick for one cycle when the count equals DIV-1, then wrap to 0.
REQ-016 The block SHALL run a sample counter 0..15 that advances on tick; a bit period is 16 ticks.
REQ-017 The block SHALL implement the states IDLE, START, DATA, STOP and BREAK_WAIT.
REQ-018 In IDLE, when rxs=0, the block SHALL clear the tick and sample counters and enter START on the next cycle.
REQ-019 The block SHALL capture rxs on the ticks at samples 7, 8 and 9; the bit value SHALL be the 2-of-3 majority.
REQ-020 In START, a majority of 1 SHALL be a false start: return to IDLE, with no output and no error.
REQ-021 In START, a majority of 0 SHALL cause entry to DATA at the end of sample 15.
REQ-022 In DATA, the block SHALL shift in 8 bits LSB first, one per bit period, and SHALL enter STOP after the 8th bit's sample 15.
REQ-023 In STOP, the block SHALL make its decision at the sample-9 tick, not at sample 15, to allow back-to-back frames.
REQ-024 A stop majority of 1 SHALL deliver the byte and move the block to IDLE.
REQ-025 A stop majority of 0 SHALL pulse frame_err, discard the byte and enter BREAK_WAIT.
REQ-026 BREAK_WAIT SHALL return to IDLE on the first cycle with rxs=1; a break or stuck-low line SHALL produce exactly one frame_err.
REQ-027 Delivery SHALL load rx_data and set rx_valid on the cycle after the stop decision.
REQ-028 rx_valid SHALL stay high and rx_data SHALL stay stable until a cycle where rx_ready=1.
REQ-029 On delivery while rx_valid=1 and rx_ready=0, the block SHALL pulse overrun, keep the old byte and drop the new one.
REQ-030 On delivery in the same cycle as a consume (rx_valid && rx_ready), the block SHALL load the new byte, keep rx_valid high and SHALL NOT pulse overrun.
REQ-031 rx_ready while rx_valid=0 SHALL have no effect.

Reset
REQ-032 With rst=1 at a clock edge, the block SHALL set: state=IDLE; counters=0; shift register=0; synchronizer=1; rx_data=8'h00; rx_valid=0; frame_err=0; overrun=0; busy=0.
REQ-033 Reset mid-frame SHALL abandon the frame without a pulse on any output; after reset the block SHALL accept a new start only when rxs=0.

Verification
Use CLOCK_FREQ=1600000 and BAUD_RATE=10000, giving DIV=10 and 160 cycles per bit.
REQ-034 The bench SHALL cover: frame 8'hA5 with a valid stop and rx_ready=1 -> rx_valid for one cycle, rx_data=8'hA5, no error pulses.
REQ-035 The bench SHALL cover: a 40-cycle low glitch on idle rx -> false start, back to IDLE, no rx_valid, no frame_err.
REQ-036 The bench SHALL cover: frame 8'h3C with the stop bit held low for 5 bit periods, then high -> one frame_err pulse, no rx_valid, busy low after rx returns high.
REQ-037 The bench SHALL cover: frames 8'h11 then 8'h22 back to back with rx_ready=0 -> rx_data=8'h11 retained, one overrun pulse; rx_ready=1 then clears rx_valid.
REQ-038 The bench SHALL cover: rx_ready=1 asserted exactly on the delivery cycle of the second byte 8'h22 -> rx_data=8'h22, rx_valid stays 1, no overrun.
REQ-039 The bench SHALL cover: rst pulsed during DATA bit 4 of 8'hFF -> all outputs at reset values; the next frame 8'h5A is received correctly.
